mem_write_checker: RTL

//  Synthesizable, parametrised self-checker for the data-memory write port of the MIPS top level.

---
 rtl/mem_write_checker.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_write_checker.sv
// rtl/mem_write_checker.sv - self-checker for the data-memory write port
// Compares each dmem write against a table of expected (addr,data) pairs and reports a registered verdict.
module mem_write_checker #(
  parameter int               WIDTH       = 32,
  parameter int               N_EXP       = 4,
  parameter int               IDX_W       = 2,
  parameter int               IGNORE_EN   = 1,
  parameter logic [WIDTH-1:0] IGNORE_ADDR = WIDTH'(80),
  parameter int               ORDERED     = 1,
  parameter int               TIMEOUT     = 1000,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             exp_we,
  input  logic [IDX_W-1:0] exp_idx,
  input  logic [WIDTH-1:0] exp_addr,
  input  logic [WIDTH-1:0] exp_data,
  input  logic [IDX_W:0]   num_exp,
  input  logic             start,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] dataadr,
  input  logic [WIDTH-1:0] writedata,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_code,
  output logic [WIDTH-1:0] fail_addr,
  output logic [WIDTH-1:0] fail_data,
  output logic [IDX_W:0]   match_count,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t           state;
  logic [WIDTH-1:0] tbl_addr [N_EXP];
  logic [WIDTH-1:0] tbl_data [N_EXP];
  logic [N_EXP-1:0] mask;
  logic [IDX_W:0]   n_lat;

  logic             wr;
  logic             hit;
  logic             addr_hit;
  logic [IDX_W-1:0] hit_idx;
  logic [IDX_W:0]   next_count;
  logic             final_hit;
  logic [IDX_W:0]   num_clamped;

  assign busy = (state == S_RUN);
  assign done = (state == S_PASS) || (state == S_FAIL);
  assign pass = (state == S_PASS);

  assign wr          = (state == S_RUN) && memwrite &&
                       !((IGNORE_EN != 0) && (dataadr == IGNORE_ADDR));
  assign next_count  = match_count + (IDX_W+1)'(1);
  assign final_hit   = hit && (next_count == n_lat);
  assign num_clamped = ((num_exp == '0) || (32'(num_exp) > N_EXP)) ? (IDX_W+1)'(1) : num_exp;

  // Unordered search runs high-to-low so the lowest matching index wins.
  always_comb begin
    hit      = 1'b0;
    addr_hit = 1'b0;
    hit_idx  = '0;
    if (ORDERED != 0) begin
      hit_idx  = match_count[IDX_W-1:0];
      addr_hit = (tbl_addr[hit_idx] == dataadr);
      hit      = addr_hit && (tbl_data[hit_idx] == writedata);
    end else begin
      for (int i = N_EXP-1; i >= 0; i--) begin
        if (((IDX_W+1)'(i) < n_lat) && !mask[i] && (tbl_addr[i] == dataadr)) begin
          addr_hit = 1'b1;
          if (tbl_data[i] == writedata) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      mask        <= '0;
      n_lat       <= '0;
      fail_code   <= 2'd0;
      fail_addr   <= '0;
      fail_data   <= '0;
      match_count <= '0;
      cycle_count <= '0;
      for (int i = 0; i < N_EXP; i++) begin
        tbl_addr[i] <= '0;
        tbl_data[i] <= '0;
      end
    end else begin
      if (exp_we && (state != S_RUN) && (32'(exp_idx) < N_EXP)) begin
        tbl_addr[exp_idx] <= exp_addr;
        tbl_data[exp_idx] <= exp_data;
      end

      if (start) begin
        state       <= S_RUN;
        n_lat       <= num_clamped;
        mask        <= '0;
        fail_code   <= 2'd0;
        fail_addr   <= '0;
        fail_data   <= '0;
        match_count <= '0;
        cycle_count <= '0;
      end else if (state == S_RUN) begin
        if (wr && hit) begin
          match_count   <= next_count;
          mask[hit_idx] <= 1'b1;
        end
        // A bad write outranks the timeout; a final match outranks it too.
        if (wr && !hit) begin
          state     <= S_FAIL;
          fail_code <= addr_hit ? 2'd3 : 2'd1;
          fail_addr <= dataadr;
          fail_data <= writedata;
        end else if (wr && final_hit) begin
          state <= S_PASS;
        end else if (cycle_count == CNT_W'(TIMEOUT - 1)) begin
          state     <= S_FAIL;
          fail_code <= 2'd2;
        end else if (cycle_count != '1) begin
          cycle_count <= cycle_count + CNT_W'(1);
        end
      end
    end
  end

endmodule
